// File: rtl/debug_command_engine.sv
// debug_command_engine
//   Byte-stream debug command processor for the CPU core. Opcodes and
//   little-endian arguments arrive on a UART byte link. The engine drives the
//   core's halt/reset/PC/register-file ports and a req/ack data-memory bus.
//   Response bytes are queued in a show-ahead TX FIFO.
//
// Ports
//   i_Clock, i_Reset_N            clock, asynchronous active-low reset
//   i_Rx_Valid, i_Rx_Byte         received byte strobe and value
//   o_Tx_Valid, o_Tx_Byte         FIFO non-empty and head byte
//   i_Tx_Ready                    head byte is taken when valid & ready
//   i_PC, i_Pipeline_Flushed      core status
//   o_Halt_Cpu, o_Reset_Cpu       sticky core control levels
//   o_Write_PC_*                  one-cycle PC write
//   o_Reg_Read_*, i_Reg_Read_Data register read (data one cycle after strobe)
//   o_Reg_Write_*                 one-cycle register write
//   o_Mem_*, i_Mem_Ack/Rdata      memory request held until ack
module debug_command_engine #(
  parameter int         DATA_WIDTH     = 32,
  parameter int         REG_ADDR_WIDTH = 5,
  parameter int         TX_FIFO_DEPTH  = 16,
  parameter int         TIMEOUT_CYCLES = 100000,
  parameter logic [7:0] PING_BYTE      = 8'hA5,
  parameter logic [7:0] ACK_BYTE       = 8'h4B
) (
  input  logic                      i_Clock,
  input  logic                      i_Reset_N,
  input  logic                      i_Rx_Valid,
  input  logic [7:0]                i_Rx_Byte,
  output logic                      o_Tx_Valid,
  output logic [7:0]                o_Tx_Byte,
  input  logic                      i_Tx_Ready,
  input  logic [DATA_WIDTH-1:0]     i_PC,
  input  logic                      i_Pipeline_Flushed,
  output logic                      o_Halt_Cpu,
  output logic                      o_Reset_Cpu,
  output logic                      o_Write_PC_Enable,
  output logic [DATA_WIDTH-1:0]     o_Write_PC_Data,
  output logic                      o_Reg_Read_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Reg_Read_Addr,
  input  logic [DATA_WIDTH-1:0]     i_Reg_Read_Data,
  output logic                      o_Reg_Write_Enable,
  output logic [REG_ADDR_WIDTH-1:0] o_Reg_Write_Addr,
  output logic [DATA_WIDTH-1:0]     o_Reg_Write_Data,
  output logic                      o_Mem_Req,
  output logic                      o_Mem_We,
  output logic [DATA_WIDTH-1:0]     o_Mem_Addr,
  output logic [DATA_WIDTH-1:0]     o_Mem_Wdata,
  input  logic                      i_Mem_Ack,
  input  logic [DATA_WIDTH-1:0]     i_Mem_Rdata
);

  localparam int         W        = DATA_WIDTH / 8;
  localparam logic [7:0] W8       = 8'(W);
  localparam int         AW       = $clog2(TX_FIFO_DEPTH);
  localparam logic [AW:0]   DEPTH_C = (AW+1)'(TX_FIFO_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [31:0]   TO_LAST = 32'(TIMEOUT_CYCLES - 1);

  localparam logic [7:0] OP_NOP       = 8'h00;
  localparam logic [7:0] OP_RESET     = 8'h01;
  localparam logic [7:0] OP_UNRESET   = 8'h02;
  localparam logic [7:0] OP_HALT      = 8'h03;
  localparam logic [7:0] OP_UNHALT    = 8'h04;
  localparam logic [7:0] OP_PING      = 8'h05;
  localparam logic [7:0] OP_READ_PC   = 8'h06;
  localparam logic [7:0] OP_WRITE_PC  = 8'h07;
  localparam logic [7:0] OP_READ_REG  = 8'h08;
  localparam logic [7:0] OP_WRITE_REG = 8'h09;
  localparam logic [7:0] OP_READ_MEM  = 8'h0A;
  localparam logic [7:0] OP_WRITE_MEM = 8'h0B;

  localparam logic [7:0] ERR_UNKNOWN  = 8'hEE;
  localparam logic [7:0] ERR_ARG_TO   = 8'hEF;
  localparam logic [7:0] ERR_MEM_TO   = 8'hEB;

  typedef enum logic [2:0] {
    S_IDLE, S_ARGS, S_WAIT_FLUSH, S_EXEC, S_WAIT_MEM, S_RESPOND
  } state_t;

  function automatic logic [7:0] arg_count(input logic [7:0] op);
    case (op)
      OP_WRITE_PC:  arg_count = W8;
      OP_READ_REG:  arg_count = 8'd1;
      OP_WRITE_REG: arg_count = W8 + 8'd1;
      OP_READ_MEM:  arg_count = W8;
      OP_WRITE_MEM: arg_count = W8 + W8;
      default:      arg_count = 8'd0;
    endcase
  endfunction

  function automatic logic halts_core(input logic [7:0] op);
    halts_core = (op == OP_WRITE_PC) || (op == OP_READ_REG) ||
                 (op == OP_WRITE_REG) || (op == OP_READ_MEM) ||
                 (op == OP_WRITE_MEM);
  endfunction

  state_t                    state_q, state_d;
  logic [7:0]                cmd_q, cmd_d;
  logic [7:0]                arg_cnt_q, arg_cnt_d;
  logic [31:0]               to_cnt_q, to_cnt_d;
  logic [REG_ADDR_WIDTH-1:0] reg_addr_q, reg_addr_d;
  logic [DATA_WIDTH-1:0]     addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic                      halt_q, halt_d;
  logic                      rst_cpu_q, rst_cpu_d;
  logic [DATA_WIDTH-1:0]     resp_data_q, resp_data_d;
  logic [7:0]                resp_len_q, resp_len_d;
  logic                      reg_cap_q, reg_cap_d;
  logic [AW-1:0]             wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]             rd_ptr_q, rd_ptr_d;
  logic [AW:0]               count_q, count_d;
  logic [7:0]                fifo_mem_q [TX_FIFO_DEPTH];

  logic fifo_full, fifo_nonempty, push, pop;
  logic is_mem_op, args_done, args_timeout, mem_timeout, resp_done;

  always_comb begin
    fifo_full     = (count_q == DEPTH_C);
    fifo_nonempty = (count_q != '0);
    pop           = fifo_nonempty && i_Tx_Ready;
    is_mem_op     = (cmd_q == OP_READ_MEM) || (cmd_q == OP_WRITE_MEM);
    args_done     = (state_q == S_ARGS) && i_Rx_Valid &&
                    ((arg_cnt_q + 8'd1) == arg_count(cmd_q));
    args_timeout  = (state_q == S_ARGS) && !i_Rx_Valid && (to_cnt_q == TO_LAST);
    mem_timeout   = (state_q == S_WAIT_MEM) && !i_Mem_Ack && (to_cnt_q == TO_LAST);
    // READ_REG spends its first RESPOND cycle capturing register data.
    push          = (state_q == S_RESPOND) && !reg_cap_q &&
                    (resp_len_q != 8'd0) && !fifo_full;
    resp_done     = (state_q == S_RESPOND) && !reg_cap_q &&
                    ((resp_len_q == 8'd0) || (push && (resp_len_q == 8'd1)));
  end

  // State and datapath registers
  always_ff @(posedge i_Clock or negedge i_Reset_N) begin
    if (!i_Reset_N) begin
      state_q     <= S_IDLE;
      cmd_q       <= '0;
      arg_cnt_q   <= '0;
      to_cnt_q    <= '0;
      reg_addr_q  <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      halt_q      <= 1'b0;
      rst_cpu_q   <= 1'b0;
      resp_data_q <= '0;
      resp_len_q  <= '0;
      reg_cap_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      arg_cnt_q   <= arg_cnt_d;
      to_cnt_q    <= to_cnt_d;
      reg_addr_q  <= reg_addr_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      halt_q      <= halt_d;
      rst_cpu_q   <= rst_cpu_d;
      resp_data_q <= resp_data_d;
      resp_len_q  <= resp_len_d;
      reg_cap_q   <= reg_cap_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // FIFO storage carries no reset; o_Tx_Byte is masked while empty.
  always_ff @(posedge i_Clock) begin
    if (push) fifo_mem_q[wr_ptr_q] <= resp_data_q[7:0];
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:
        if (i_Rx_Valid) state_d = (arg_count(i_Rx_Byte) != 8'd0) ? S_ARGS : S_EXEC;
      S_ARGS:
        if (args_timeout)   state_d = S_RESPOND;
        else if (args_done) state_d = S_WAIT_FLUSH;
      S_WAIT_FLUSH:
        if (i_Pipeline_Flushed) state_d = S_EXEC;
      S_EXEC:
        state_d = is_mem_op ? S_WAIT_MEM : S_RESPOND;
      S_WAIT_MEM:
        if (i_Mem_Ack || mem_timeout) state_d = S_RESPOND;
      S_RESPOND:
        if (resp_done) state_d = S_IDLE;
      default:
        state_d = S_IDLE;
    endcase
  end

  // Argument collection, command side effects and response staging
  always_comb begin
    cmd_d       = cmd_q;
    arg_cnt_d   = arg_cnt_q;
    to_cnt_d    = to_cnt_q;
    reg_addr_d  = reg_addr_q;
    addr_d      = addr_q;
    data_d      = data_q;
    halt_d      = halt_q;
    rst_cpu_d   = rst_cpu_q;
    resp_data_d = resp_data_q;
    resp_len_d  = resp_len_q;
    reg_cap_d   = reg_cap_q;

    case (state_q)
      S_IDLE: begin
        if (i_Rx_Valid) begin
          cmd_d     = i_Rx_Byte;
          arg_cnt_d = 8'd0;
          to_cnt_d  = '0;
          if (halts_core(i_Rx_Byte)) halt_d = 1'b1;
        end
      end
      S_ARGS: begin
        if (i_Rx_Valid) begin
          to_cnt_d  = '0;
          arg_cnt_d = arg_cnt_q + 8'd1;
          // Fields fill by shifting in from the top, so LSB-first bytes
          // land little-endian after W shifts.
          if ((cmd_q == OP_READ_REG || cmd_q == OP_WRITE_REG) && arg_cnt_q == 8'd0)
            reg_addr_d = i_Rx_Byte[REG_ADDR_WIDTH-1:0];
          else if (cmd_q == OP_READ_MEM || (cmd_q == OP_WRITE_MEM && arg_cnt_q < W8))
            addr_d = {i_Rx_Byte, addr_q[DATA_WIDTH-1:8]};
          else
            data_d = {i_Rx_Byte, data_q[DATA_WIDTH-1:8]};
        end else begin
          to_cnt_d = to_cnt_q + 32'd1;
          if (args_timeout) begin
            resp_data_d = DATA_WIDTH'(ERR_ARG_TO);
            resp_len_d  = 8'd1;
          end
        end
      end
      S_EXEC: begin
        resp_len_d = 8'd0;
        to_cnt_d   = '0;
        case (cmd_q)
          OP_NOP:     ;
          OP_RESET:   rst_cpu_d = 1'b1;
          OP_UNRESET: rst_cpu_d = 1'b0;
          OP_HALT:    halt_d    = 1'b1;
          OP_UNHALT:  halt_d    = 1'b0;
          OP_PING: begin
            resp_data_d = DATA_WIDTH'(PING_BYTE);
            resp_len_d  = 8'd1;
          end
          OP_READ_PC: begin
            resp_data_d = i_PC;
            resp_len_d  = W8;
          end
          OP_WRITE_PC, OP_WRITE_REG: begin
            resp_data_d = DATA_WIDTH'(ACK_BYTE);
            resp_len_d  = 8'd1;
          end
          OP_READ_REG: begin
            resp_len_d = W8;
            reg_cap_d  = 1'b1;
          end
          OP_READ_MEM, OP_WRITE_MEM: ;
          default: begin
            resp_data_d = DATA_WIDTH'(ERR_UNKNOWN);
            resp_len_d  = 8'd1;
          end
        endcase
      end
      S_WAIT_MEM: begin
        to_cnt_d = to_cnt_q + 32'd1;
        if (i_Mem_Ack) begin
          if (cmd_q == OP_READ_MEM) begin
            resp_data_d = i_Mem_Rdata;
            resp_len_d  = W8;
          end else begin
            resp_data_d = DATA_WIDTH'(ACK_BYTE);
            resp_len_d  = 8'd1;
          end
        end else if (mem_timeout) begin
          resp_data_d = DATA_WIDTH'(ERR_MEM_TO);
          resp_len_d  = 8'd1;
        end
      end
      S_RESPOND: begin
        if (reg_cap_q) begin
          resp_data_d = i_Reg_Read_Data;
          reg_cap_d   = 1'b0;
        end else if (push) begin
          resp_data_d = resp_data_q >> 8;
          resp_len_d  = resp_len_q - 8'd1;
        end
      end
      default: ;
    endcase
  end

  // FIFO pointers and occupancy
  always_comb begin
    wr_ptr_d = push ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop  ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Outputs
  always_comb begin
    o_Tx_Valid         = fifo_nonempty;
    o_Tx_Byte          = fifo_nonempty ? fifo_mem_q[rd_ptr_q] : 8'h00;
    o_Halt_Cpu         = halt_q;
    o_Reset_Cpu        = rst_cpu_q;
    o_Write_PC_Enable  = (state_q == S_EXEC) && (cmd_q == OP_WRITE_PC);
    o_Write_PC_Data    = data_q;
    o_Reg_Read_Enable  = (state_q == S_EXEC) && (cmd_q == OP_READ_REG);
    o_Reg_Read_Addr    = reg_addr_q;
    o_Reg_Write_Enable = (state_q == S_EXEC) && (cmd_q == OP_WRITE_REG);
    o_Reg_Write_Addr   = reg_addr_q;
    o_Reg_Write_Data   = data_q;
    // Request rises in EXEC and is held through the ack cycle of WAIT_MEM.
    o_Mem_Req          = ((state_q == S_EXEC) && is_mem_op) || (state_q == S_WAIT_MEM);
    o_Mem_We           = o_Mem_Req && (cmd_q == OP_WRITE_MEM);
    o_Mem_Addr         = addr_q;
    o_Mem_Wdata        = data_q;
  end

endmodule

// File: tb/tb_debug_command_engine.sv
// Testbench for debug_command_engine: directed command sequences, a byte-level
// response model (expected TX queue) and a per-cycle compare process.
module tb_debug_command_engine;
  localparam int DW = 32;
  localparam int RA = 5;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_valid = 1'b0;
  logic [7:0]    rx_byte = 8'h00;
  logic          tx_valid;
  logic [7:0]    tx_byte;
  logic          tx_ready = 1'b1;
  logic [DW-1:0] pc = '0;
  logic          flushed = 1'b1;
  logic          halt, rst_cpu, pc_we, rd_en, rw_en, mem_req, mem_we;
  logic [DW-1:0] pc_wdata, rw_data, mem_addr, mem_wdata;
  logic [RA-1:0] rd_addr, rw_addr;
  logic [DW-1:0] reg_rdata = 32'hBAD0_BAD0;
  logic          mem_ack = 1'b0;
  logic [DW-1:0] mem_rdata = '0;

  always #5 clk = ~clk;

  debug_command_engine #(
    .DATA_WIDTH(DW), .REG_ADDR_WIDTH(RA), .TX_FIFO_DEPTH(16), .TIMEOUT_CYCLES(50),
    .PING_BYTE(8'hA5), .ACK_BYTE(8'h4B)
  ) dut (
    .i_Clock(clk), .i_Reset_N(rst_n), .i_Rx_Valid(rx_valid), .i_Rx_Byte(rx_byte),
    .o_Tx_Valid(tx_valid), .o_Tx_Byte(tx_byte), .i_Tx_Ready(tx_ready),
    .i_PC(pc), .i_Pipeline_Flushed(flushed), .o_Halt_Cpu(halt), .o_Reset_Cpu(rst_cpu),
    .o_Write_PC_Enable(pc_we), .o_Write_PC_Data(pc_wdata),
    .o_Reg_Read_Enable(rd_en), .o_Reg_Read_Addr(rd_addr), .i_Reg_Read_Data(reg_rdata),
    .o_Reg_Write_Enable(rw_en), .o_Reg_Write_Addr(rw_addr), .o_Reg_Write_Data(rw_data),
    .o_Mem_Req(mem_req), .o_Mem_We(mem_we), .o_Mem_Addr(mem_addr), .o_Mem_Wdata(mem_wdata),
    .i_Mem_Ack(mem_ack), .i_Mem_Rdata(mem_rdata)
  );

  int total = 0;
  int bad = 0;
  logic [7:0] exp_q[$];
  logic [7:0] log_q[$];
  int pc_pulses = 0, wr_pulses = 0, rd_pulses = 0, req_cycles = 0;
  logic [DW-1:0] exp_pc_data = '0, exp_rw_data = '0, exp_mem_addr = '0, exp_mem_wdata = '0;
  logic [RA-1:0] exp_rw_addr = '0;
  logic          exp_mem_we = 1'b0;
  logic          rd_seen = 1'b0;
  logic [RA-1:0] rd_addr_seen = '0;

  function automatic logic [DW-1:0] reg_val(input logic [RA-1:0] a);
    return {8'hC0, 8'h0F, 8'hEE, 3'b000, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW/8; i++) exp_q.push_back(w[8*i +: 8]);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_byte  = b;
    tick(1);
    rx_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      tick(1);
      n++;
    end
    chk({name, "_pending_bytes"}, exp_q.size(), 0);
    exp_q.delete();
    tick(3);
  endtask

  task automatic wait_req(input string name);
    int n = 0;
    while (!mem_req && n < 30) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req_seen"}, mem_req, 1);
  endtask

  // Compare process: TX bytes against the model queue, side-effect pulses
  // against the expected command fields.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tx_valid && tx_ready) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL tx_unexpected: got %0h with no byte outstanding", tx_byte);
        end else begin
          chk("tx_byte", tx_byte, exp_q.pop_front());
        end
        log_q.push_back(tx_byte);
      end
      if (pc_we) begin
        pc_pulses++;
        chk("pc_write_data", pc_wdata, exp_pc_data);
      end
      if (rw_en) begin
        wr_pulses++;
        chk("reg_write_addr", rw_addr, exp_rw_addr);
        chk("reg_write_data", rw_data, exp_rw_data);
      end
      if (rd_en) rd_pulses++;
      if (mem_req) begin
        req_cycles++;
        chk("mem_addr", mem_addr, exp_mem_addr);
        chk("mem_we", mem_we, exp_mem_we);
        if (exp_mem_we) chk("mem_wdata", mem_wdata, exp_mem_wdata);
      end
    end
    rd_seen      = rd_en;
    rd_addr_seen = rd_addr;
  end

  // Register file: read data valid in the cycle after the strobe.
  initial forever begin
    @(posedge clk);
    #1;
    reg_rdata = rd_seen ? reg_val(rd_addr_seen) : 32'hBAD0_BAD0;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tick(3);
    chk("reset_halt", halt, 0);
    chk("reset_rst_cpu", rst_cpu, 0);
    chk("reset_tx_valid", tx_valid, 0);
    chk("reset_tx_byte", tx_byte, 0);
    chk("reset_mem_req", mem_req, 0);
    rst_n = 1'b1;
    tick(2);

    // PING then READ_PC
    pc = 32'h8000_0124;
    log_q.delete();
    exp_q.push_back(8'hA5);
    send(8'h05);
    tick(4);
    expect_word(pc);
    send(8'h06);
    wait_drain("ping_readpc", 40);
    chk("t1_log_len", log_q.size(), 5);
    chk("t1_byte0", log_q[0], 8'hA5);
    chk("t1_byte1", log_q[1], 8'h24);
    chk("t1_byte4", log_q[4], 8'h80);

    // RESET / UNRESET levels
    send(8'h01);
    tick(3);
    chk("reset_cpu_set", rst_cpu, 1);
    send(8'h02);
    tick(3);
    chk("reset_cpu_clear", rst_cpu, 0);

    // WRITE_REG held in WAIT_FLUSH until the pipeline drains
    flushed     = 1'b0;
    exp_rw_addr = 5'd5;
    exp_rw_data = 32'h1234_5678;
    exp_q.push_back(8'h4B);
    send(8'h09); send(8'h05); send(8'h78); send(8'h56); send(8'h34); send(8'h12);
    tick(3);
    chk("wreg_no_early_write", wr_pulses, 0);
    chk("wreg_halt_set", halt, 1);
    flushed = 1'b1;
    wait_drain("write_reg", 40);
    chk("wreg_one_pulse", wr_pulses, 1);
    chk("wreg_halt_held", halt, 1);
    send(8'h04);
    tick(3);
    chk("unhalt_clears", halt, 0);

    // READ_MEM with ack in the 7th request cycle
    exp_mem_addr = 32'h0000_1000;
    exp_mem_we   = 1'b0;
    req_cycles   = 0;
    log_q.delete();
    expect_word(32'hDEAD_BEEF);
    send(8'h0A); send(8'h00); send(8'h10); send(8'h00); send(8'h00);
    wait_req("rmem");
    repeat (6) @(posedge clk);
    #1;
    mem_ack   = 1'b1;
    mem_rdata = 32'hDEAD_BEEF;
    tick(1);
    mem_ack   = 1'b0;
    chk("rmem_req_dropped", mem_req, 0);
    wait_drain("read_mem", 40);
    chk("rmem_req_cycles", req_cycles, 7);
    chk("rmem_byte0", log_q[0], 8'hEF);
    chk("rmem_byte3", log_q[3], 8'hDE);

    // WRITE_MEM with ack in the 2nd request cycle
    exp_mem_addr  = 32'h0000_2000;
    exp_mem_we    = 1'b1;
    exp_mem_wdata = 32'h4433_2211;
    req_cycles    = 0;
    exp_q.push_back(8'h4B);
    send(8'h0B); send(8'h00); send(8'h20); send(8'h00); send(8'h00);
    send(8'h11); send(8'h22); send(8'h33); send(8'h44);
    wait_req("wmem");
    @(posedge clk);
    #1;
    mem_ack = 1'b1;
    tick(1);
    mem_ack = 1'b0;
    wait_drain("write_mem", 40);
    chk("wmem_req_cycles", req_cycles, 2);

    // WRITE_PC with 2 of 4 argument bytes times out
    pc_pulses = 0;
    exp_q.push_back(8'hEF);
    send(8'h07); send(8'h11); send(8'h22);
    tick(40);
    chk("argto_not_early", tx_valid, 0);
    wait_drain("arg_timeout", 40);
    chk("argto_no_pc_write", pc_pulses, 0);
    exp_q.push_back(8'hA5);
    send(8'h05);
    wait_drain("ping_after_timeout", 20);

    // Full WRITE_PC
    exp_pc_data = 32'hCAFE_0010;
    exp_q.push_back(8'h4B);
    send(8'h07); send(8'h10); send(8'h00); send(8'hFE); send(8'hCA);
    wait_drain("write_pc", 40);
    chk("wpc_one_pulse", pc_pulses, 1);

    // FIFO backpressure: 5 READ_PC = 20 bytes into a 16-deep FIFO
    tx_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      pc = 32'hA0B0_C000 + 32'(k * 'h11);
      expect_word(pc);
      send(8'h06);
      tick(8);
    end
    chk("fifo_full_valid", tx_valid, 1);
    send(8'h05);  // engine is stalled in RESPOND: must be discarded
    tick(20);
    log_q.delete();
    tx_ready = 1'b1;
    wait_drain("fifo_drain", 80);
    chk("fifo_drain_count", log_q.size(), 20);
    chk("fifo_byte0", log_q[0], 8'h00);
    chk("fifo_byte16", log_q[16], 8'h44);
    chk("fifo_byte19", log_q[19], 8'hA0);
    chk("fifo_empty_after", tx_valid, 0);

    // Unknown opcode and READ_REG
    exp_q.push_back(8'hEE);
    send(8'h7F);
    wait_drain("unknown_op", 20);
    rd_pulses = 0;
    log_q.delete();
    expect_word(reg_val(5'd3));
    send(8'h08); send(8'h03);
    wait_drain("read_reg", 40);
    chk("rreg_one_strobe", rd_pulses, 1);
    chk("rreg_byte0", log_q[0], 8'h03);
    chk("rreg_byte3", log_q[3], 8'hC0);

    // Reset asserted while READ_MEM waits for ack
    exp_mem_addr = 32'h0000_3000;
    exp_mem_we   = 1'b0;
    send(8'h0A); send(8'h00); send(8'h30); send(8'h00); send(8'h00);
    wait_req("abort");
    #2;
    rst_n = 1'b0;
    #1;
    chk("abort_req_low", mem_req, 0);
    chk("abort_tx_empty", tx_valid, 0);
    chk("abort_halt_low", halt, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(2);
    exp_q.push_back(8'hA5);
    send(8'h05);
    wait_drain("ping_after_reset", 20);

    tick(5);
    chk("final_idle_tx", tx_valid, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
